// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer: FSM states,
// sequencing opcodes and microword field positions.
package useq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Sequencing opcodes carried in the low three bits of each microword
  localparam logic [2:0] OP_INC     = 3'b000;
  localparam logic [2:0] OP_JMP     = 3'b001;
  localparam logic [2:0] OP_JC      = 3'b010;
  localparam logic [2:0] OP_JZ      = 3'b011;
  localparam logic [2:0] OP_CALL    = 3'b100;
  localparam logic [2:0] OP_RET     = 3'b101;
  localparam logic [2:0] OP_RESTART = 3'b110;
  localparam logic [2:0] OP_HALT    = 3'b111;

  // Field positions inside the 24-bit microword
  localparam int SEQ_LO = 0;
  localparam int SEQ_HI = 2;
  localparam int TGT_LO = 13;
  localparam int TGT_HI = 20;

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for CALL/RET. Push and pop are ignored when the
// stack is full or empty respectively; the caller turns those cases
// into a fault.
module useq_stack
  import useq_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic          full,
  output logic          empty
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [IW-1:0]  top_idx;

  assign full     = (sp == SPW'(DEPTH));
  assign empty    = (sp == '0);
  assign top_idx  = IW'(sp - 1'b1);
  assign top_data = mem[top_idx];

  // Stack pointer: counts valid entries, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // Entry storage: written at the current pointer on a successful push
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[IW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/useq_ctrl.sv
// Microprogram sequencer: fetches microwords over a request/valid ROM
// handshake, strobes each one to the datapath for a single cycle and
// computes the next micro-address, including call/return via a small
// hardware stack. Stack over/underflow halts the sequencer with a
// sticky fault.
module useq_ctrl
  import useq_pkg::*;
#(
  parameter int AW    = 8,
  parameter int UW    = 24,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  output logic [AW-1:0] rom_addr,
  output logic          rom_rd,
  input  logic [UW-1:0] rom_data,
  input  logic          rom_valid,
  output logic [UW-1:0] uword,
  output logic          uword_valid,
  input  logic          carry_in,
  input  logic          zero_in,
  output logic          halted,
  output logic          fault,
  output logic [AW-1:0] upc
);

  state_t        state;
  logic [2:0]    op;
  logic [AW-1:0] target;
  logic [AW-1:0] upc_inc;
  logic [AW-1:0] next_upc;
  logic [AW-1:0] stack_top;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_push;
  logic          stack_pop;
  logic          exec_fault;
  logic          in_exec;

  assign op       = uword[SEQ_HI:SEQ_LO];
  assign target   = uword[TGT_HI:TGT_LO];
  assign upc_inc  = upc + 1'b1;
  assign in_exec  = (state == ST_EXEC);
  assign rom_addr = upc;

  useq_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stack_push),
    .pop       (stack_pop),
    .push_data (upc_inc),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // Next-address decode for the microword being executed; stack traffic
  // and faults are only raised while actually in EXEC
  always_comb begin
    next_upc   = upc_inc;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    exec_fault = 1'b0;
    case (op)
      OP_INC:     next_upc = upc_inc;
      OP_JMP:     next_upc = target;
      OP_JC:      next_upc = carry_in ? target : upc_inc;
      OP_JZ:      next_upc = zero_in ? target : upc_inc;
      OP_CALL: begin
        if (stack_full) begin
          next_upc   = upc;
          exec_fault = in_exec;
        end else begin
          next_upc   = target;
          stack_push = in_exec;
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          next_upc   = upc;
          exec_fault = in_exec;
        end else begin
          next_upc  = stack_top;
          stack_pop = in_exec;
        end
      end
      OP_RESTART: next_upc = '0;
      OP_HALT:    next_upc = upc;
      default:    next_upc = upc_inc;
    endcase
  end

  // Sequencer FSM with registered handshake, strobe and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      upc         <= '0;
      rom_rd      <= 1'b0;
      uword       <= '0;
      uword_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run || step) begin
            state  <= ST_FETCH;
            rom_rd <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (rom_valid) begin
            uword       <= rom_data;
            uword_valid <= 1'b1;
            rom_rd      <= 1'b0;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          uword_valid <= 1'b0;
          upc         <= next_upc;
          if (op == OP_HALT || exec_fault) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            if (exec_fault) begin
              fault <= 1'b1;
            end
          end else if (run) begin
            state  <= ST_FETCH;
            rom_rd <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          halted <= 1'b1;
          rom_rd <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/useq_ctrl.md
Name: useq_ctrl

Overview:
- Microprogram sequencer for the 8-bit bus CPU; replaces the bare micro-PC counter.
- Fetches 24-bit microwords from the microcode ROM with a request/valid handshake and presents each word to the datapath decoders and ALU as a one-cycle execute strobe.
- Computes the next micro-address (increment, jump, conditional jump on flags, call/return), supports run/single-step/halt, and flags stack faults.

Parameters:
- AW, 8, micro-address width
- UW, 24, microword width
- DEPTH, 4, call/return stack entries (power of two)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- run  in  1  level; 1 = free-run sequencing
- step  in  1  single-cycle pulse; runs one microword when run=0 and state=IDLE
- rom_addr  out  AW  micro-address to ROM
- rom_rd  out  1  ROM read request
- rom_data  in  UW  ROM read data
- rom_valid  in  1  rom_data valid; honoured only in FETCH
- uword  out  UW  current microword to decoders/ALU
- uword_valid  out  1  one-cycle execute strobe
- carry_in  in  1  carry flag from status register
- zero_in  in  1  zero flag from status register
- halted  out  1  1 while in HALT
- fault  out  1  sticky stack over/underflow flag
- upc  out  AW  current micro-PC (debug LEDs)

Behaviour:
- Reset values: state=IDLE, upc=0, rom_rd=0, uword=0, uword_valid=0, halted=0, fault=0, stack pointer=0 (empty). Reset overrides everything, including mid-fetch; a pending rom_valid after reset is ignored.
- Sequencing field is uword[2:0]. Target address is uword[20:13].
  - 000 INC: upc+1; 0xFF wraps to 0x00.
  - 001 JMP: upc=target.
  - 010 JC: target if carry_in, else upc+1.
  - 011 JZ: target if zero_in, else upc+1.
  - 100 CALL: push upc+1 (wrapping), upc=target.
  - 101 RET: upc=pop.
  - 110 RESTART: upc=0.
  - 111 HALT: upc unchanged, enter HALT.
- States:
  - IDLE: rom_rd=0. Go to FETCH if run=1, or if run=0 and step=1.
  - FETCH: rom_rd=1 and rom_addr=upc, both held stable until rom_valid. On rom_valid, capture rom_data into uword and go to EXEC. Minimum latency is 1 cycle (valid in the first FETCH cycle).
  - EXEC: exactly 1 cycle with uword_valid=1. Flags are sampled this cycle and reflect the previous microword. upc updates at the end of the cycle. Next state: HALT if op=HALT or a fault occurs; else FETCH if run=1; else IDLE.
  - HALT: halted=1, rom_rd=0. Only rst exits.
- uword holds its value outside EXEC; only uword_valid qualifies it.
- Throughput: one microword per 2 cycles with zero-wait ROM.
- run dropping mid-FETCH: the fetch and its EXEC complete, then IDLE. No aborted reads.
- step while run=1 is ignored. A step during FETCH/EXEC is ignored (not queued).
- CALL with a full stack (DEPTH entries): no push, upc unchanged, fault=1, enter HALT.
- RET with an empty stack: same fault handling.
- CALL and RET cannot occur in the same cycle (single op field).
- fault is cleared only by rst.

Decomposition:
- Package useq_pkg:
  - state encoding (IDLE, FETCH, EXEC, HALT)
  - 3-bit sequencing op constants
  - field positions: SEQ_LO=0, SEQ_HI=2, TGT_LO=13, TGT_HI=20
- One sub-module, useq_stack: LIFO of DEPTH x AW with push/pop/full/empty and synchronous active-high reset.

Test Plan:
- Reset then run=1 with zero-wait ROM of INC words -> rom_addr 0,1,2,… every 2 cycles; uword_valid pulses on alternate cycles; upc reaches 0xFF then wraps to 0x00.
- Word at 0x05 = JC target 0x40: carry_in=1 -> next rom_addr 0x40; carry_in=0 -> next rom_addr 0x06. Repeat with JZ/zero_in.
- CALL 0x80 at 0x10, RET at 0x80 -> fetch sequence 0x10, 0x80, 0x11. Five nested CALLs (DEPTH=4) -> fifth sets fault=1, halted=1, upc stays at the fifth CALL's address, no further rom_rd.
- rom_valid delayed 3 cycles -> rom_rd and rom_addr stable for all 4 FETCH cycles, exactly one uword_valid; drop run during this FETCH -> EXEC completes, then IDLE with rom_rd=0.
- run=0 with step pulses -> exactly one fetch+execute per pulse; step asserted during EXEC ignored; step with run=1 has no extra effect.
- rst asserted mid-FETCH and mid-HALT -> next cycle upc=0, rom_rd=0, halted=0, fault=0, stack empty (an immediate RET faults).
